// File: rtl/word_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_game_pkg
// Description : Shared types and helpers for the word-scramble game
//               controller: state encoding, default letter-count range and
//               the swap-index validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package word_game_pkg;

    // Controller states; encoding 3'd7 is unused and recovers to ST_INIT.
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_GETWORD  = 3'd2,
        ST_SWAP     = 3'd3,
        ST_CORRECT  = 3'd4,
        ST_GAMEOVER = 3'd5,
        ST_LOGOUT   = 3'd6
    } state_t;

    localparam int c_MIN_LETT_DEF = 4;
    localparam int c_MAX_LETT_DEF = 6;

    // A swap is legal when both indices address a letter of the current
    // word and they name two different letters.
    function automatic logic swapValid(input int unsigned i1,
                                       input int unsigned i2,
                                       input int unsigned n);
        return (i1 < n) && (i2 < n) && (i1 != i2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hi_score_table.sv
`default_nettype none
// ============================================================================
// Module      : hi_score_table
// Description : Per-player high-score register file, 2**PID_W entries of
//               SCORE_W bits, cleared asynchronously on reset.
// Ports       : clk, rst (async, active low)
//               we, waddr, wdata  - single write port
//               raddr, rdata      - registered read port (one-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module hi_score_table #(
    parameter int PID_W   = 3,
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [PID_W-1:0]   waddr,
    input  logic [SCORE_W-1:0] wdata,
    input  logic [PID_W-1:0]   raddr,
    output logic [SCORE_W-1:0] rdata
);

    localparam int c_DEPTH = 2**PID_W;

    logic [SCORE_W-1:0] r_mem [c_DEPTH];
    logic [SCORE_W-1:0] r_rdata;

    generate
        for (genvar g = 0; g < c_DEPTH; g++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_mem[g] <= '0;
                end else if (we && (waddr == PID_W'(g))) begin
                    r_mem[g] <= wdata;
                end
            end
        end
    endgenerate

    // Reads the pre-write contents: a write lands on rdata one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/word_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : word_game_ctrl
// Description : Second-generation word-scramble game controller. Sequences
//               login, letter-count selection, word fetch, scramble, player
//               swaps, saturating scoring, game-over with per-player
//               high-score tracking, and logout. All outputs registered.
// Ports       : clk, rst (async, active low)
//               logOn, pwdPls, startPls, loadPls - button pulses
//               isCorrect, timeOut               - level inputs
//               pIDin, gIDin, indIn1, indIn2     - IDs and swap indices
//               logOut, timerEn, lettNum, indOut1/2, score, hiScore,
//               pIDout, gIDout, state            - registered status
//               scramPls, flipPls, swapErr, timerReconfig, newHigh
//                                                - one-cycle strobes
// Revision    : 1.0 - initial release
// ============================================================================
module word_game_ctrl
    import word_game_pkg::*;
#(
    parameter int MIN_LETT = c_MIN_LETT_DEF,
    parameter int MAX_LETT = c_MAX_LETT_DEF,
    parameter int IDX_W    = 3,
    parameter int SCORE_W  = 7,
    parameter int PID_W    = 3,
    parameter int GID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               logOn,
    input  logic               pwdPls,
    input  logic               startPls,
    input  logic               loadPls,
    input  logic               isCorrect,
    input  logic               timeOut,
    input  logic [PID_W-1:0]   pIDin,
    input  logic [GID_W-1:0]   gIDin,
    input  logic [IDX_W-1:0]   indIn1,
    input  logic [IDX_W-1:0]   indIn2,
    output logic               logOut,
    output logic               scramPls,
    output logic               flipPls,
    output logic               swapErr,
    output logic               timerEn,
    output logic               timerReconfig,
    output logic [IDX_W-1:0]   lettNum,
    output logic [IDX_W-1:0]   indOut1,
    output logic [IDX_W-1:0]   indOut2,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiScore,
    output logic               newHigh,
    output logic [PID_W-1:0]   pIDout,
    output logic [GID_W-1:0]   gIDout,
    output logic [2:0]         state
);

    localparam logic [IDX_W-1:0]   c_MIN   = IDX_W'(MIN_LETT);
    localparam logic [IDX_W-1:0]   c_MAX   = IDX_W'(MAX_LETT);
    localparam logic [SCORE_W-1:0] c_S_MAX = '1;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_mode, w_mode;
    logic [IDX_W-1:0]   r_lettNum, w_lettNum;
    logic               r_logOut, w_logOut;
    logic               r_scramPls, w_scramPls;
    logic               r_flipPls, w_flipPls;
    logic               r_swapErr, w_swapErr;
    logic               r_timerEn, w_timerEn;
    logic               r_timerReconfig, w_timerReconfig;
    logic [IDX_W-1:0]   r_indOut1, w_indOut1;
    logic [IDX_W-1:0]   r_indOut2, w_indOut2;
    logic [SCORE_W-1:0] r_score, w_score;
    logic               r_newHigh, w_newHigh;
    logic [PID_W-1:0]   r_pIDout, w_pIDout;
    logic [GID_W-1:0]   r_gIDout, w_gIDout;
    logic               w_tableWe;
    logic [SCORE_W-1:0] w_tableRd;
    logic               w_swapOk;

    assign w_swapOk = swapValid(int'(indIn1), int'(indIn2), int'(r_lettNum));

    // The stored best for the logged-in player is read through the
    // registered port; pIDin is held steady for the duration of a game, so
    // the value seen in GAMEOVER belongs to the same player being written.
    hi_score_table #(
        .PID_W   (PID_W),
        .SCORE_W (SCORE_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (w_tableWe),
        .waddr (pIDin),
        .wdata (r_score),
        .raddr (pIDin),
        .rdata (w_tableRd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_INIT;
            r_mode          <= c_MIN;
            r_lettNum       <= c_MIN;
            r_logOut        <= 1'b0;
            r_scramPls      <= 1'b0;
            r_flipPls       <= 1'b0;
            r_swapErr       <= 1'b0;
            r_timerEn       <= 1'b0;
            r_timerReconfig <= 1'b0;
            r_indOut1       <= '0;
            r_indOut2       <= '0;
            r_score         <= '0;
            r_newHigh       <= 1'b0;
            r_pIDout        <= '0;
            r_gIDout        <= '0;
        end else begin
            r_state         <= w_state;
            r_mode          <= w_mode;
            r_lettNum       <= w_lettNum;
            r_logOut        <= w_logOut;
            r_scramPls      <= w_scramPls;
            r_flipPls       <= w_flipPls;
            r_swapErr       <= w_swapErr;
            r_timerEn       <= w_timerEn;
            r_timerReconfig <= w_timerReconfig;
            r_indOut1       <= w_indOut1;
            r_indOut2       <= w_indOut2;
            r_score         <= w_score;
            r_newHigh       <= w_newHigh;
            r_pIDout        <= w_pIDout;
            r_gIDout        <= w_gIDout;
        end
    end

    always_comb begin
        w_state         = r_state;
        w_mode          = r_mode;
        w_lettNum       = r_lettNum;
        w_logOut        = r_logOut;
        w_scramPls      = 1'b0;
        w_flipPls       = 1'b0;
        w_swapErr       = 1'b0;
        w_timerEn       = r_timerEn;
        w_timerReconfig = 1'b0;
        w_indOut1       = r_indOut1;
        w_indOut2       = r_indOut2;
        w_score         = r_score;
        w_newHigh       = 1'b0;
        w_pIDout        = r_pIDout;
        w_gIDout        = r_gIDout;
        w_tableWe       = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_mode = c_MIN;
                if (logOn) begin
                    w_timerEn = 1'b1;
                    w_state   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // lettNum trails mode by one cycle.
                w_lettNum = r_mode;
                if (pwdPls) begin
                    w_logOut = 1'b1;
                    w_state  = ST_LOGOUT;
                end else if (loadPls) begin
                    w_mode = (r_mode == c_MAX) ? c_MIN : r_mode + IDX_W'(1);
                end else if (startPls) begin
                    w_score         = '0;
                    w_timerReconfig = 1'b1;
                    w_state         = ST_GETWORD;
                end
            end
            ST_GETWORD: begin
                if (startPls) begin
                    w_state = ST_SETUP;
                end else if (timeOut) begin
                    w_state = ST_GAMEOVER;
                end else if (pwdPls) begin
                    w_scramPls = 1'b1;
                    w_state    = ST_SWAP;
                end
            end
            ST_SWAP: begin
                if (startPls) begin
                    w_state = ST_SETUP;
                end else if (timeOut) begin
                    w_state = ST_GAMEOVER;
                end else if (isCorrect) begin
                    w_state = ST_CORRECT;
                end else if (loadPls) begin
                    if (w_swapOk) begin
                        w_indOut1 = indIn1;
                        w_indOut2 = indIn2;
                        w_flipPls = 1'b1;
                    end else begin
                        w_swapErr = 1'b1;
                    end
                end
            end
            ST_CORRECT: begin
                w_score = (r_score == c_S_MAX) ? r_score : r_score + SCORE_W'(1);
                w_state = ST_GETWORD;
            end
            ST_GAMEOVER: begin
                w_pIDout  = pIDin;
                w_gIDout  = gIDin;
                w_timerEn = 1'b0;
                w_mode    = c_MIN;
                w_state   = ST_SETUP;
                // Strictly greater: a tie keeps the existing record.
                if (r_score > w_tableRd) begin
                    w_tableWe = 1'b1;
                    w_newHigh = 1'b1;
                end
            end
            ST_LOGOUT: begin
                w_timerEn = 1'b0;
                w_logOut  = 1'b0;
                w_state   = ST_INIT;
            end
            default: begin
                w_state = ST_INIT;
            end
        endcase
    end

    assign logOut        = r_logOut;
    assign scramPls      = r_scramPls;
    assign flipPls       = r_flipPls;
    assign swapErr       = r_swapErr;
    assign timerEn       = r_timerEn;
    assign timerReconfig = r_timerReconfig;
    assign lettNum       = r_lettNum;
    assign indOut1       = r_indOut1;
    assign indOut2       = r_indOut2;
    assign score         = r_score;
    assign hiScore       = w_tableRd;
    assign newHigh       = r_newHigh;
    assign pIDout        = r_pIDout;
    assign gIDout        = r_gIDout;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_word_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_game_ctrl
// Description : Directed self-checking bench for word_game_ctrl. Drives two
//               instances from the same stimulus: A with default parameters
//               and B with MIN_LETT=3, MAX_LETT=7, SCORE_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, logOn, pwdPls, startPls, loadPls, isCorrect, timeOut;
    logic [2:0] pIDin, gIDin, indIn1, indIn2;

    logic       logOutA, scramA, flipA, swapErrA, timerEnA, reconfA, newHighA;
    logic [2:0] lettA, ind1A, ind2A, pIDoutA, gIDoutA, stateA;
    logic [6:0] scoreA, hiA;

    logic       logOutB, scramB, flipB, swapErrB, timerEnB, reconfB, newHighB;
    logic [2:0] lettB, ind1B, ind2B, pIDoutB, gIDoutB, stateB;
    logic [2:0] scoreB, hiB;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    word_game_ctrl dutA (
        .clk(clk), .rst(rst), .logOn(logOn), .pwdPls(pwdPls),
        .startPls(startPls), .loadPls(loadPls), .isCorrect(isCorrect),
        .timeOut(timeOut), .pIDin(pIDin), .gIDin(gIDin),
        .indIn1(indIn1), .indIn2(indIn2), .logOut(logOutA),
        .scramPls(scramA), .flipPls(flipA), .swapErr(swapErrA),
        .timerEn(timerEnA), .timerReconfig(reconfA), .lettNum(lettA),
        .indOut1(ind1A), .indOut2(ind2A), .score(scoreA), .hiScore(hiA),
        .newHigh(newHighA), .pIDout(pIDoutA), .gIDout(gIDoutA),
        .state(stateA)
    );

    word_game_ctrl #(.MIN_LETT(3), .MAX_LETT(7), .SCORE_W(3)) dutB (
        .clk(clk), .rst(rst), .logOn(logOn), .pwdPls(pwdPls),
        .startPls(startPls), .loadPls(loadPls), .isCorrect(isCorrect),
        .timeOut(timeOut), .pIDin(pIDin), .gIDin(gIDin),
        .indIn1(indIn1), .indIn2(indIn2), .logOut(logOutB),
        .scramPls(scramB), .flipPls(flipB), .swapErr(swapErrB),
        .timerEn(timerEnB), .timerReconfig(reconfB), .lettNum(lettB),
        .indOut1(ind1B), .indOut2(ind2B), .score(scoreB), .hiScore(hiB),
        .newHigh(newHighB), .pIDout(pIDoutB), .gIDout(gIDoutB),
        .state(stateB)
    );

    task automatic check(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SWAP -> CORRECT -> GETWORD (score+1) -> SWAP
    task automatic correctPass();
        isCorrect = 1'b1; tick(); isCorrect = 1'b0;
        tick();
        pwdPls = 1'b1; tick(); pwdPls = 1'b0;
    endtask

    // SETUP -> GETWORD -> SWAP
    task automatic startGame();
        startPls = 1'b1; tick(); startPls = 1'b0;
        pwdPls = 1'b1; tick(); pwdPls = 1'b0;
    endtask

    // SWAP -> GAMEOVER -> SETUP
    task automatic gameOver();
        timeOut = 1'b1; tick(); timeOut = 1'b0;
        tick();
    endtask

    int expLettA [6] = '{5, 6, 4, 5, 6, 4};
    int expLettB [6] = '{4, 5, 6, 7, 3, 4};

    initial begin
        rst = 1'b0; logOn = 1'b0; pwdPls = 1'b0; startPls = 1'b0;
        loadPls = 1'b0; isCorrect = 1'b0; timeOut = 1'b0;
        pIDin = 3'd3; gIDin = 3'd5; indIn1 = 3'd0; indIn2 = 3'd0;

        // Reset state
        tick(); tick();
        check("rst_state", int'(stateA), 0);
        check("rst_lettA", int'(lettA), 4);
        check("rst_lettB", int'(lettB), 3);
        check("rst_timerEn", int'(timerEnA), 0);
        check("rst_score", int'(scoreA), 0);
        check("rst_hiScore", int'(hiA), 0);
        rst = 1'b1;

        // Login
        logOn = 1'b1; tick(); logOn = 1'b0;
        check("login_state", int'(stateA), 1);
        check("login_timerEn", int'(timerEnA), 1);

        // Letter-count cycling: six presses return both to mode 4
        for (int i = 0; i < 6; i++) begin
            loadPls = 1'b1; tick(); loadPls = 1'b0;
            tick();
            check("lettNumA", int'(lettA), expLettA[i]);
            check("lettNumB", int'(lettB), expLettB[i]);
        end

        // Start game: timer reload strobe
        startPls = 1'b1; tick(); startPls = 1'b0;
        check("start_state", int'(stateA), 2);
        check("start_reconf", int'(reconfA), 1);
        tick();
        check("reconf_drop", int'(reconfA), 0);
        pwdPls = 1'b1; tick(); pwdPls = 1'b0;
        check("swap_state", int'(stateA), 3);
        check("scramPls", int'(scramA), 1);

        // Valid swap (1,3)
        indIn1 = 3'd1; indIn2 = 3'd3;
        loadPls = 1'b1; tick(); loadPls = 1'b0;
        check("flipA", int'(flipA), 1);
        check("flipB", int'(flipB), 1);
        check("ind1", int'(ind1A), 1);
        check("ind2", int'(ind2A), 3);
        check("swapErr_valid", int'(swapErrA), 0);
        tick();
        check("flip_drop", int'(flipA), 0);

        // Equal indices (2,2)
        indIn1 = 3'd2; indIn2 = 3'd2;
        loadPls = 1'b1; tick(); loadPls = 1'b0;
        check("swapErr_eq", int'(swapErrA), 1);
        check("flip_eq", int'(flipA), 0);

        // Out of range (0,4) with lettNum=4
        indIn1 = 3'd0; indIn2 = 3'd4;
        loadPls = 1'b1; tick(); loadPls = 1'b0;
        check("swapErr_rangeA", int'(swapErrA), 1);
        check("swapErr_rangeB", int'(swapErrB), 1);
        check("ind1_hold", int'(ind1A), 1);
        check("ind2_hold", int'(ind2A), 3);
        tick();
        check("swapErr_drop", int'(swapErrA), 0);

        // Score 4, then time out -> new high score for player 3
        for (int i = 0; i < 4; i++) correctPass();
        check("score4A", int'(scoreA), 4);
        check("score4B", int'(scoreB), 4);
        gameOver();
        check("go_state", int'(stateA), 1);
        check("go_newHighA", int'(newHighA), 1);
        check("go_newHighB", int'(newHighB), 1);
        check("go_pIDout", int'(pIDoutA), 3);
        check("go_gIDout", int'(gIDoutA), 5);
        check("go_timerEn", int'(timerEnA), 0);
        tick();
        check("hiScoreA", int'(hiA), 4);
        check("hiScoreB", int'(hiB), 4);
        check("newHigh_drop", int'(newHighA), 0);

        // Second game, tie at 4 -> no record
        startGame();
        for (int i = 0; i < 4; i++) correctPass();
        gameOver();
        check("tie_score", int'(scoreA), 4);
        check("tie_newHigh", int'(newHighA), 0);

        // timeOut + isCorrect together -> GAMEOVER, no increment
        startGame();
        correctPass();
        timeOut = 1'b1; isCorrect = 1'b1; tick();
        timeOut = 1'b0; isCorrect = 1'b0;
        check("to_ic_state", int'(stateA), 5);
        tick();
        check("to_ic_score", int'(scoreA), 1);
        check("to_ic_newHigh", int'(newHighA), 0);

        // startPls + timeOut together -> SETUP
        startGame();
        startPls = 1'b1; timeOut = 1'b1; tick();
        startPls = 1'b0; timeOut = 1'b0;
        check("st_to_state", int'(stateA), 1);
        check("st_to_newHigh", int'(newHighA), 0);
        tick();
        check("st_to_newHigh2", int'(newHighA), 0);

        // Logout and log back in: table persists
        pwdPls = 1'b1; tick(); pwdPls = 1'b0;
        check("lo_state", int'(stateA), 6);
        check("lo_logOut", int'(logOutA), 1);
        tick();
        check("lo_init", int'(stateA), 0);
        check("lo_logOut0", int'(logOutA), 0);
        logOn = 1'b1; tick(); logOn = 1'b0;
        check("relog_state", int'(stateA), 1);
        check("relog_hiScore", int'(hiA), 4);

        // Saturation: B holds at 7
        startGame();
        for (int i = 0; i < 8; i++) correctPass();
        check("sat8A", int'(scoreA), 8);
        check("sat8B", int'(scoreB), 7);
        correctPass();
        check("sat9A", int'(scoreA), 9);
        check("sat9B", int'(scoreB), 7);

        // Asynchronous reset mid-game
        #2 rst = 1'b0;
        #1;
        check("ar_state", int'(stateA), 0);
        check("ar_score", int'(scoreA), 0);
        check("ar_lettA", int'(lettA), 4);
        check("ar_lettB", int'(lettB), 3);
        check("ar_ind1", int'(ind1A), 0);
        check("ar_pIDout", int'(pIDoutA), 0);
        check("ar_timerEn", int'(timerEnA), 0);
        rst = 1'b1;
        pIDin = 3'd2;
        tick(); tick();
        check("ar_hi2", int'(hiA), 0);
        pIDin = 3'd3;
        tick(); tick();
        check("ar_hi3", int'(hiA), 0);
        check("ar_state2", int'(stateA), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
